// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues program-memory reads and buffers
// the tagged responses in a 2-entry skid FIFO presented to decode.
module instruction_fetch_unit #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  output logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0] mem_instruction,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0] instr_pc
);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  inflightValid_q, inflightValid_d;
  logic [ADDR_WIDTH-1:0] inflightPc_q, inflightPc_d;
  logic [1:0]            count_q, count_d;
  logic                  rdPtr_q, rdPtr_d;
  logic                  wrPtr_q, wrPtr_d;
  logic [ADDR_WIDTH-1:0] fifoPc_q [2];
  logic [DATA_WIDTH-1:0] fifoData_q [2];

  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] occupancy;

  assign mem_address = pc_q;
  assign instr_valid = (count_q != 2'd0);
  // Head is forced to zero when empty so reset/flush never exposes stale entries.
  assign instr_data  = instr_valid ? fifoData_q[rdPtr_q] : '0;
  assign instr_pc    = instr_valid ? fifoPc_q[rdPtr_q]   : '0;

  always_comb begin
    pop       = instr_valid & instr_ready;
    push      = inflightValid_q & ~redirect_valid;
    occupancy = {1'b0, count_q} + {2'b00, inflightValid_q} - {2'b00, pop};
    issue     = run & ~redirect_valid & (occupancy < 3'd2);

    pc_d            = pc_q;
    inflightValid_d = issue;
    inflightPc_d    = inflightPc_q;
    count_d         = count_q + {1'b0, push} - {1'b0, pop};
    rdPtr_d         = pop  ? ~rdPtr_q : rdPtr_q;
    wrPtr_d         = push ? ~wrPtr_q : wrPtr_q;

    if (issue) begin
      pc_d         = pc_q + 1'b1;
      inflightPc_d = pc_q;
    end

    // A redirect kills the in-flight response and everything already buffered.
    if (redirect_valid) begin
      pc_d            = redirect_target;
      inflightValid_d = 1'b0;
      count_d         = 2'd0;
      rdPtr_d         = 1'b0;
      wrPtr_d         = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q            <= RESET_PC;
      inflightValid_q <= 1'b0;
      inflightPc_q    <= '0;
      count_q         <= 2'd0;
      rdPtr_q         <= 1'b0;
      wrPtr_q         <= 1'b0;
    end else begin
      pc_q            <= pc_d;
      inflightValid_q <= inflightValid_d;
      inflightPc_q    <= inflightPc_d;
      count_q         <= count_d;
      rdPtr_q         <= rdPtr_d;
      wrPtr_q         <= wrPtr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifoPc_q[wrPtr_q]   <= inflightPc_q;
      fifoData_q[wrPtr_q] <= mem_instruction;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus random traffic,
// with a scoreboard holding the expected in-order (pc, data) delivery stream.
module tb_instruction_fetch_unit;

  typedef struct packed {
    logic [7:0] pc;
    logic [7:0] data;
  } item_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [7:0] mem_address;
  logic [7:0] memInstruction = '0;
  logic       redirect_valid = 1'b0;
  logic [7:0] redirect_target = '0;
  logic       instr_valid;
  logic       instr_ready = 1'b0;
  logic [7:0] instr_data;
  logic [7:0] instr_pc;

  logic [7:0] mem [256];
  item_t      expQ [$];
  int         checks = 0;
  int         passes = 0;
  int         deliveries = 0;
  logic       prevHeld = 1'b0;
  item_t      heldItem;

  instruction_fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .run             (run),
    .mem_address     (mem_address),
    .mem_instruction (memInstruction),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_data      (instr_data),
    .instr_pc        (instr_pc)
  );

  always #5 clk = ~clk;

  // Synchronous program memory: data for the address seen at an edge appears after it.
  always @(posedge clk) memInstruction <= mem[mem_address];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // After reset or redirect, decode must see consecutive PCs from the start point.
  task automatic pushStream(input logic [7:0] start);
    item_t it;
    expQ.delete();
    for (int i = 0; i < 1024; i++) begin
      it.pc   = start + 8'(i);
      it.data = mem[it.pc];
      expQ.push_back(it);
    end
  endtask

  task automatic applyStimulus(input logic rs, input logic runV, input logic rdyV,
                               input logic rvV, input logic [7:0] tgt);
    rst             = rs;
    run             = runV;
    instr_ready     = rdyV;
    redirect_valid  = rvV;
    redirect_target = tgt;
    if (rs) pushStream(8'h00);
    else if (rvV) pushStream(tgt);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (prevHeld) begin
      checkOutput("held_valid", {31'd0, instr_valid}, 32'd1);
      checkOutput("held_pc", {24'd0, instr_pc}, {24'd0, heldItem.pc});
      checkOutput("held_data", {24'd0, instr_data}, {24'd0, heldItem.data});
    end
    prevHeld = instr_valid & ~instr_ready & ~rst & ~redirect_valid;
    heldItem = '{pc: instr_pc, data: instr_data};
    if (!rst && !redirect_valid && instr_valid && instr_ready) begin
      deliveries++;
      if (expQ.size() == 0) begin
        checks++;
        $display("[TB] FAIL scoreboard_empty: got pc %0h, expected no delivery", instr_pc);
      end else begin
        item_t exp;
        exp = expQ.pop_front();
        checkOutput("deliver_pc", {24'd0, instr_pc}, {24'd0, exp.pc});
        checkOutput("deliver_data", {24'd0, instr_data}, {24'd0, exp.data});
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h00; mem[1] = 8'h11; mem[2] = 8'h22; mem[3] = 8'h33;

    applyStimulus(1, 0, 0, 0, 8'h00);
    applyStimulus(1, 0, 0, 0, 8'h00);
    checkOutput("reset_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("reset_data", {24'd0, instr_data}, 32'd0);
    checkOutput("reset_pc", {24'd0, instr_pc}, 32'd0);
    checkOutput("reset_addr", {24'd0, mem_address}, 32'd0);

    // Streaming from reset: two-edge latency, one instruction per cycle.
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(0, 1, 1, 0, 8'h00);
      checkOutput("stream_addr", {24'd0, mem_address}, 32'(k));
      checkOutput("stream_valid", {31'd0, instr_valid}, (k >= 2) ? 32'd1 : 32'd0);
      if (k >= 2) checkOutput("stream_pc", {24'd0, instr_pc}, 32'(k - 2));
    end

    // Backpressure: FIFO fills, issue stops at pc 2, head holds.
    applyStimulus(1, 0, 0, 0, 8'h00);
    for (int k = 0; k < 5; k++) applyStimulus(0, 1, 0, 0, 8'h00);
    checkOutput("bp_addr", {24'd0, mem_address}, 32'd2);
    checkOutput("bp_data", {24'd0, instr_data}, 32'h00);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 1, 1, 0, 8'h00);
      checkOutput("bp_drain_valid", {31'd0, instr_valid}, 32'd1);
    end

    // Redirect while pc0 is buffered and pc1 in flight.
    applyStimulus(1, 0, 0, 0, 8'h00);
    applyStimulus(0, 1, 1, 0, 8'h00);
    applyStimulus(0, 1, 1, 0, 8'h00);
    applyStimulus(0, 1, 1, 1, 8'h06);
    checkOutput("redir_flush", {31'd0, instr_valid}, 32'd0);
    checkOutput("redir_addr", {24'd0, mem_address}, 32'h06);
    applyStimulus(0, 1, 1, 0, 8'h00);
    checkOutput("redir_gap", {31'd0, instr_valid}, 32'd0);
    applyStimulus(0, 1, 1, 0, 8'h00);
    checkOutput("redir_pc", {24'd0, instr_pc}, 32'h06);

    // Wrap through 8'hFF.
    applyStimulus(0, 1, 1, 1, 8'hFE);
    for (int k = 0; k <= 5; k++) begin
      applyStimulus(0, 1, 1, 0, 8'h00);
      if (k >= 1 && k <= 4) checkOutput("wrap_pc", {24'd0, instr_pc}, {24'd0, 8'hFE + 8'(k - 1)});
    end

    // run low: in-flight work drains, pc holds at 04, then resumes there.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 0, 1, 0, 8'h00);
      checkOutput("halt_addr", {24'd0, mem_address}, 32'h04);
    end
    checkOutput("halt_drained", {31'd0, instr_valid}, 32'd0);
    applyStimulus(0, 1, 1, 0, 8'h00);
    applyStimulus(0, 1, 1, 0, 8'h00);
    checkOutput("resume_valid", {31'd0, instr_valid}, 32'd1);
    checkOutput("resume_pc", {24'd0, instr_pc}, 32'h04);

    // Reset mid-stream.
    applyStimulus(1, 1, 1, 0, 8'h00);
    checkOutput("midrst_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("midrst_addr", {24'd0, mem_address}, 32'd0);
    applyStimulus(0, 1, 1, 0, 8'h00);
    applyStimulus(0, 1, 1, 0, 8'h00);
    checkOutput("restart_valid", {31'd0, instr_valid}, 32'd1);
    checkOutput("restart_pc", {24'd0, instr_pc}, 32'd0);

    // Random traffic; the scoreboard checks every delivery.
    deliveries = 0;
    for (int k = 0; k < 2000; k++) begin
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 8,
                    $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0, 8'($urandom));
    end
    for (int k = 0; k < 6; k++) applyStimulus(0, 0, 1, 0, 8'h00);
    checkOutput("final_drained", {31'd0, instr_valid}, 32'd0);
    checkOutput("enough_deliveries", {31'd0, deliveries >= 200}, 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Requester side of the program-memory interface.
- Owns the program counter and drives the 8-bit fetch address into program memory.
- Program memory returns the instruction registered one clock later; this block tags that data with its PC and buffers it in a 2-entry skid FIFO.
- Presents the buffered instructions to decode over a valid/ready handshake, and accepts branch/jump redirects from execute.

Parameters:
- ADDR_WIDTH, 8, width of PC and memory address.
- DATA_WIDTH, 8, width of instruction word.
- RESET_PC, 8'h00, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- run  input  1  fetch enable; when low, no new fetches are issued.
- mem_address  output  ADDR_WIDTH  fetch address to program memory; equals the pc register.
- mem_instruction  input  DATA_WIDTH  program memory data; holds mem[address] sampled at the previous edge.
- redirect_valid  input  1  one-cycle pulse from execute (taken beq / j).
- redirect_target  input  ADDR_WIDTH  new PC; valid while redirect_valid is high.
- instr_valid  output  1  FIFO head is valid.
- instr_ready  input  1  decode accepts the head.
- instr_data  output  DATA_WIDTH  head instruction.
- instr_pc  output  ADDR_WIDTH  PC of the head instruction.

Behaviour:
- State:
  - pc[7:0]
  - inflight_valid, inflight_pc: the fetch issued at the previous edge
  - FIFO: 2 entries of {pc, data}, plus count 0..2
- Reset (rst=1 at an edge):
  - pc=RESET_PC, inflight_valid=0, count=0.
  - Outputs: mem_address=RESET_PC, instr_valid=0, instr_data=0, instr_pc=0.
  - rst has priority over every other input.
- pop = instr_valid & instr_ready.
- push = inflight_valid & ~redirect_valid. Data is {inflight_pc, mem_instruction}, written at the edge.
- issue = run & ~redirect_valid & ((count + inflight_valid - pop) < 2).
  - This guarantees the FIFO never overflows.
  - Sustained throughput is 1 instruction/cycle while instr_ready=1.
- On issue at an edge:
  - inflight_valid<=1, inflight_pc<=pc.
  - pc<=pc+1, modulo 2^ADDR_WIDTH (8'hFF wraps to 8'h00).
- No issue at an edge: inflight_valid<=0 and pc holds.
- Latency:
  - Address A is on mem_address before edge E and issue=1 at E.
  - mem_instruction=mem[A] in the following cycle; it is written to the FIFO at E+1.
  - instr_valid=1 after E+1 if the FIFO was empty.
  - Issue to instr_valid is 2 edges.
- Redirect (redirect_valid=1 at an edge):
  - pc<=redirect_target.
  - FIFO flushed (count<=0); a simultaneous pop is ignored.
  - inflight_valid<=0; the response arriving that cycle is discarded.
  - No issue that edge. The next edge issues redirect_target if run=1.
  - Redirect while run=0 still loads pc and flushes.
- FIFO ordering:
  - Strict order.
  - Simultaneous push and pop: count unchanged, head advances.
  - Pop at count=0 is impossible because instr_valid=0.
- Output stability: instr_data/instr_pc stay stable while instr_valid=1 and instr_ready=0.
- run deasserted: the in-flight fetch still completes into the FIFO, and the FIFO drains normally.
- Reset mid-operation: in-flight data is dropped and the FIFO is cleared at that edge.

Test Plan:
1. Memory holds {00,11,22,33} at 0..3. Hold rst for 2 edges, release, run=1, instr_ready=1:
   - mem_address is 0,1,2,3 on successive cycles.
   - instr_valid rises 2 edges after the first issue.
   - Outputs are (pc,data) = (0,00),(1,11),(2,22),(3,33) on consecutive cycles.
2. Backpressure: instr_ready=0 after start:
   - count reaches 2 and issues stop with pc=2.
   - instr_data holds 00.
   - Raise instr_ready: 00,11,22,33 delivered with no gaps or duplicates.
3. Redirect: pulse redirect_valid with target=8'h06 while entries 1,2 are buffered or in flight:
   - FIFO empties the next cycle.
   - The next delivered instruction has instr_pc=6.
   - No PC 1–3 data appears after the pulse.
4. Wrap: redirect to 8'hFE:
   - instr_pc sequence is FE,FF,00,01.
5. run=0 with one fetch in flight:
   - That one instruction is delivered and pc holds.
   - Setting run=1 resumes at the held pc.
6. rst asserted mid-stream with instr_valid=1:
   - After the edge, instr_valid=0 and mem_address=RESET_PC.
   - The post-release sequence restarts at PC 0.
